// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: block words or a sliding window of the last WIDTH bits,
// with configurable bit order and explicit word-alignment sync.
module serial_deserializer #(
  parameter int unsigned WIDTH     = 3,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          SLIDING   = 1'b0,
  localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             sync,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             sync_err
);

  localparam logic [CW-1:0] LastPos = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, base, shifted;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d, pos;
  logic             err_q, err_d;
  logic             primed_q, primed_d, primed_cur;

  // A sync bit starts a fresh word, so it shifts into an already-cleared register.
  assign base = sync ? '0 : sr_q;

  if (WIDTH == 1) begin : g_w1
    assign shifted = in;
  end else if (MSB_FIRST) begin : g_msb
    assign shifted = {base[WIDTH-2:0], in};
  end else begin : g_lsb
    assign shifted = {in, base[WIDTH-1:1]};
  end

  always_comb begin
    sr_d       = sr_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    err_d      = sync && (cnt_q != '0) && (!SLIDING || !primed_q);
    pos        = sync ? '0 : cnt_q;
    primed_cur = sync ? 1'b0 : primed_q;

    if (sync) begin
      sr_d     = '0;
      cnt_d    = '0;
      primed_d = 1'b0;
    end

    if (in_valid) begin
      sr_d = shifted;
      if (!SLIDING) begin
        if (pos == LastPos) begin
          out_d   = shifted;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = pos + 1'b1;
        end
      end else begin
        // Count saturates at the last position; from then on every bit yields a window.
        if (pos == LastPos) begin
          primed_d = 1'b1;
          cnt_d    = pos;
        end else begin
          cnt_d = pos + 1'b1;
        end
        if (primed_cur || (pos == LastPos)) begin
          out_d   = shifted;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      primed_q <= primed_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign bit_cnt   = cnt_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: four deserializer configurations share one stimulus stream and are
// checked against a bit-history model every cycle.
module tb_serial_deserializer;

  localparam int NI = 4;
  int unsigned W [NI] = '{3, 4, 3, 1};
  bit          M [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          S [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic din = 1'b0;
  logic sync = 1'b0;

  logic [2:0] out0, out2;
  logic [3:0] out1;
  logic [0:0] out3;
  logic [1:0] cnt0, cnt1, cnt2;
  logic [0:0] cnt3;
  logic [NI-1:0] v_o, e_o;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(3), .MSB_FIRST(1'b1), .SLIDING(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din), .sync(sync),
    .out(out0), .out_valid(v_o[0]), .bit_cnt(cnt0), .sync_err(e_o[0]));
  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .SLIDING(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din), .sync(sync),
    .out(out1), .out_valid(v_o[1]), .bit_cnt(cnt1), .sync_err(e_o[1]));
  serial_deserializer #(.WIDTH(3), .MSB_FIRST(1'b1), .SLIDING(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din), .sync(sync),
    .out(out2), .out_valid(v_o[2]), .bit_cnt(cnt2), .sync_err(e_o[2]));
  serial_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1), .SLIDING(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din), .sync(sync),
    .out(out3), .out_valid(v_o[3]), .bit_cnt(cnt3), .sync_err(e_o[3]));

  logic [31:0] obs_out [NI];
  logic [31:0] obs_cnt [NI];
  always_comb begin
    obs_out[0] = 32'(out0);
    obs_out[1] = 32'(out1);
    obs_out[2] = 32'(out2);
    obs_out[3] = 32'(out3);
    obs_cnt[0] = 32'(cnt0);
    obs_cnt[1] = 32'(cnt1);
    obs_cnt[2] = 32'(cnt2);
    obs_cnt[3] = 32'(cnt3);
  end

  // Model state
  bit          hist [NI][$];
  logic [31:0] sbq  [NI][$];
  int unsigned mcnt [NI];
  bit          mprimed [NI];
  bit          mv [NI];
  bit          merr [NI];
  logic [31:0] mout [NI];

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int k);
    logic [31:0] w = '0;
    for (int j = 0; j < int'(W[k]); j++) begin
      if (M[k]) w[W[k]-1-j] = hist[k][j];
      else      w[j] = hist[k][j];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      hist[k].delete();
      sbq[k].delete();
      mcnt[k] = 0;
      mprimed[k] = 1'b0;
      mv[k] = 1'b0;
      merr[k] = 1'b0;
      mout[k] = '0;
    end
  endtask

  task automatic model_step(input bit v, input bit b, input bit s);
    logic [31:0] w;
    for (int k = 0; k < NI; k++) begin
      merr[k] = s && (mcnt[k] != 0) && (!S[k] || !mprimed[k]);
      mv[k] = 1'b0;
      if (s) begin
        hist[k].delete();
        mcnt[k] = 0;
        mprimed[k] = 1'b0;
      end
      if (v) begin
        hist[k].push_back(b);
        if (hist[k].size() > W[k]) void'(hist[k].pop_front());
        if (!S[k]) begin
          if (mcnt[k] == W[k] - 1) begin
            w = word_of(k);
            sbq[k].push_back(w);
            mout[k] = w;
            mv[k] = 1'b1;
            mcnt[k] = 0;
            hist[k].delete();
          end else begin
            mcnt[k]++;
          end
        end else begin
          if (mcnt[k] == W[k] - 1) mprimed[k] = 1'b1;
          else mcnt[k]++;
          if (mprimed[k]) begin
            w = word_of(k);
            sbq[k].push_back(w);
            mout[k] = w;
            mv[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("d%0d.bit_cnt", k), obs_cnt[k], mcnt[k]);
      check($sformatf("d%0d.sync_err", k), 32'(e_o[k]), 32'(merr[k]));
      check($sformatf("d%0d.out_valid", k), 32'(v_o[k]), 32'(mv[k]));
      check($sformatf("d%0d.out_hold", k), obs_out[k], mout[k]);
      if (v_o[k]) begin
        if (sbq[k].size() == 0) begin
          check($sformatf("d%0d.spurious_strobe", k), 32'(v_o[k]), 32'd0);
        end else begin
          e = sbq[k].pop_front();
          check($sformatf("d%0d.sb_word", k), obs_out[k], e);
        end
      end
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit s);
    @(negedge clk);
    in_valid = v;
    din = b;
    sync = s;
    model_step(v, b, s);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bits(input logic [31:0] pat, input int n, input int max_gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, pat[i], 1'b0);
      if (max_gap > 0) begin
        for (int g = 0; g < int'($urandom_range(0, max_gap)); g++) drive(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    bits(32'b101110, 6, 0);          // continuous stream
    bits(32'b101110, 6, 3);          // same stream with idle gaps
    bits(32'b1100, 4, 0);
    bits(32'b10, 2, 0);
    drive(1'b1, 1'b0, 1'b1);         // sync mid-word with a bit
    bits(32'b11, 2, 0);
    bits(32'b1, 1, 0);
    drive(1'b0, 1'b0, 1'b1);         // sync without a bit
    drive(1'b0, 1'b0, 1'b1);         // sync at bit_cnt 0
    bits(32'b01, 2, 0);
    drive(1'b1, 1'b1, 1'b1);         // sync on the would-be completing bit
    bits(32'b10110, 5, 0);

    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0);
    end

    // Asynchronous reset mid-word
    bits(32'b10, 2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    sync = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("d%0d.rst_out", k), obs_out[k], 32'd0);
      check($sformatf("d%0d.rst_valid", k), 32'(v_o[k]), 32'd0);
      check($sformatf("d%0d.rst_cnt", k), obs_cnt[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bits(32'b111, 3, 0);
    drive(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
